// File: rtl/bist_engine_if.sv
// Core-side BIST bus: the request/grant channels and the scan port of the
// arbiter core. The engine is the master and the core is the slave.
interface bist_engine_if #(
  parameter int N_CH = 4
);
  logic [N_CH-1:0] dut_req;
  logic [N_CH-1:0] dut_grant;
  logic            dut_reset;
  logic            dut_scan_en;
  logic            dut_scan_in;
  logic            dut_scan_out;

  modport master (
    output dut_req, dut_reset, dut_scan_en, dut_scan_in,
    input  dut_grant, dut_scan_out
  );

  modport slave (
    input  dut_req, dut_reset, dut_scan_en, dut_scan_in,
    output dut_grant, dut_scan_out
  );
endinterface

// File: rtl/bist_engine.sv
// Built-in self-test engine for an N-channel request/grant arbiter core.
// Passes functional traffic through when idle. A BIST run resets the core,
// drives LFSR patterns, unloads the scan chain and compacts grants plus scan
// data into a MISR that is finally compared with a golden signature.
module bist_engine #(
  parameter int                  N_CH       = 4,
  parameter int                  LFSR_W     = 16,
  parameter logic [LFSR_W-1:0]   LFSR_TAPS  = LFSR_W'(16'hB400),
  parameter logic [LFSR_W-1:0]   LFSR_SEED  = LFSR_W'(16'hACE1),
  parameter int                  MISR_W     = 16,
  parameter logic [MISR_W-1:0]   MISR_POLY  = MISR_W'(16'h1021),
  parameter int                  N_PATTERNS = 64,
  parameter int                  SCAN_LEN   = 8,
  parameter logic [MISR_W-1:0]   GOLDEN     = MISR_W'(16'h6BD2)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              bist_start,
  input  logic              bist_abort,
  input  logic [N_CH-1:0]   func_req,
  output logic [N_CH-1:0]   grant_o,
  bist_engine_if.master     core,
  output logic              bist_busy,
  output logic              bist_end,
  output logic              pass_fail,
  output logic [MISR_W-1:0] signature_out
);

  localparam int CNT_W = $clog2(N_PATTERNS + SCAN_LEN + 1);

  typedef enum logic [2:0] {IDLE, INIT, RUN, SCAN, DONE} state_t;

  state_t             state, state_next;
  logic [CNT_W-1:0]   cnt, cnt_next;
  logic [LFSR_W-1:0]  lfsr, lfsr_next, lfsr_step;
  logic [MISR_W-1:0]  misr, misr_next, misr_step, compact;
  logic               pass_q, pass_next;
  logic               scan_bit;

  // State, counter, pattern generator, signature and verdict registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state  <= IDLE;
      cnt    <= '0;
      lfsr   <= LFSR_SEED;
      misr   <= '0;
      pass_q <= 1'b0;
    end else begin
      state  <= state_next;
      cnt    <= cnt_next;
      lfsr   <= lfsr_next;
      misr   <= misr_next;
      pass_q <= pass_next;
    end
  end

  // Sequencing: abort wins over everything, start is honoured only when idle/done.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    case (state)
      IDLE, DONE: begin
        if (bist_start && !bist_abort) begin
          state_next = INIT;
          cnt_next   = '0;
        end
      end
      INIT: begin
        if (bist_abort) begin
          state_next = IDLE;
        end else begin
          state_next = RUN;
          cnt_next   = '0;
        end
      end
      RUN: begin
        if (bist_abort) begin
          state_next = IDLE;
        end else if (cnt == CNT_W'(N_PATTERNS - 1)) begin
          state_next = SCAN;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt + 1'b1;
        end
      end
      SCAN: begin
        if (bist_abort) begin
          state_next = IDLE;
        end else if (cnt == CNT_W'(SCAN_LEN - 1)) begin
          state_next = DONE;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt + 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // LFSR/MISR stepping; the MISR compacts the grant answering the previous pattern.
  always_comb begin
    scan_bit         = (state == SCAN) ? core.dut_scan_out : 1'b0;
    compact          = '0;
    compact[N_CH:0]  = {scan_bit, core.dut_grant};
    lfsr_step        = {lfsr[LFSR_W-2:0], ^(lfsr & LFSR_TAPS)};
    misr_step        = {misr[MISR_W-2:0], 1'b0}
                       ^ (misr[MISR_W-1] ? MISR_POLY : '0)
                       ^ compact;
    lfsr_next        = lfsr;
    misr_next        = misr;
    if (state_next == INIT) begin
      lfsr_next = LFSR_SEED;
      misr_next = '0;
    end else if ((state == RUN || state == SCAN) && !bist_abort) begin
      lfsr_next = lfsr_step;
      misr_next = misr_step;
    end
  end

  // Verdict is captured on the edge that enters DONE, cleared whenever DONE is left.
  always_comb begin
    pass_next = pass_q;
    if (state == SCAN && state_next == DONE) begin
      pass_next = (misr_next == GOLDEN);
    end else if (state_next != DONE) begin
      pass_next = 1'b0;
    end
  end

  // Pin/core muxing: BIST owns the core while busy, otherwise straight passthrough.
  always_comb begin
    bist_busy        = (state == INIT) || (state == RUN) || (state == SCAN);
    bist_end         = (state == DONE);
    pass_fail        = pass_q && (state == DONE);
    signature_out    = misr;
    core.dut_reset   = ~reset | (state == INIT);
    core.dut_scan_en = (state == SCAN);
    core.dut_scan_in = (state == SCAN) ? lfsr[0] : 1'b0;
    core.dut_req     = bist_busy ? lfsr[N_CH-1:0] : func_req;
    grant_o          = bist_busy ? '0 : core.dut_grant;
  end

endmodule

// File: tb/tb_bist_engine.sv
// Self-checking bench for bist_engine: behavioural loopback cores with an
// 8-bit scan chain, a signature reference model, and directed scenarios.
module tb_bist_engine;

  // Reference signature: loopback core (grant = req), scan chain reset to A5.
  function automatic logic [31:0] ref_sig(input int nch, input int mw, input int npat,
                                          input int slen, input logic [31:0] poly,
                                          input bit faulty);
    logic [15:0] lf;
    logic [31:0] ms, g, comp;
    logic [7:0]  chain;
    logic        s, fb;
    lf    = 16'hACE1;
    ms    = 32'h0;
    chain = 8'hA5;
    for (int k = 0; k < npat + slen; k++) begin
      g = {16'h0, lf} & ((32'h1 << nch) - 32'h1);
      if (faulty) g[2] = 1'b0;
      s    = (k >= npat) ? chain[7] : 1'b0;
      comp = g | ({31'h0, s} << nch);
      fb   = ms[mw-1];
      ms   = ((ms << 1) ^ (fb ? poly : 32'h0) ^ comp) & ((32'h1 << mw) - 32'h1);
      if (k >= npat) chain = {chain[6:0], lf[0]};
      lf = {lf[14:0], ^(lf & 16'hB400)};
    end
    return ms;
  endfunction

  localparam logic [31:0] S_DFLT  = ref_sig(4, 16, 64, 8, 32'h1021, 1'b0);
  localparam logic [31:0] S_FAULT = ref_sig(4, 16, 64, 8, 32'h1021, 1'b1);
  localparam logic [31:0] S_SWEEP = ref_sig(8, 12, 1, 1, 32'h021, 1'b0);

  logic        clock = 1'b0;
  logic        reset;
  logic        bist_start, bist_abort, fault_en;
  logic [3:0]  func_req;
  logic [7:0]  func_req8;
  logic [3:0]  grant_a, grant_b;
  logic [7:0]  grant_c;
  logic        busy_a, end_a, pass_a, busy_b, end_b, pass_b, busy_c, end_c, pass_c;
  logic [15:0] sig_a, sig_b;
  logic [11:0] sig_c;
  logic [7:0]  chain_a, chain_b, chain_c;
  int          num_checks = 0;
  int          num_errors = 0;

  bist_engine_if #(.N_CH(4)) if_a ();
  bist_engine_if #(.N_CH(4)) if_b ();
  bist_engine_if #(.N_CH(8)) if_c ();

  always #5 clock = ~clock;

  // Behavioural cores: combinational loopback grant, scan chain reset by dut_reset.
  assign if_a.dut_grant    = if_a.dut_req;
  assign if_b.dut_grant    = if_b.dut_req & ~{1'b0, fault_en, 2'b00};
  assign if_c.dut_grant    = if_c.dut_req;
  assign if_a.dut_scan_out = chain_a[7];
  assign if_b.dut_scan_out = chain_b[7];
  assign if_c.dut_scan_out = chain_c[7];

  always @(posedge clock) begin
    if (if_a.dut_reset) chain_a <= 8'hA5;
    else if (if_a.dut_scan_en) chain_a <= {chain_a[6:0], if_a.dut_scan_in};
    if (if_b.dut_reset) chain_b <= 8'hA5;
    else if (if_b.dut_scan_en) chain_b <= {chain_b[6:0], if_b.dut_scan_in};
    if (if_c.dut_reset) chain_c <= 8'hA5;
    else if (if_c.dut_scan_en) chain_c <= {chain_c[6:0], if_c.dut_scan_in};
  end

  bist_engine u_a (
    .clock(clock), .reset(reset), .bist_start(bist_start), .bist_abort(bist_abort),
    .func_req(func_req), .grant_o(grant_a), .core(if_a), .bist_busy(busy_a),
    .bist_end(end_a), .pass_fail(pass_a), .signature_out(sig_a)
  );

  bist_engine #(.GOLDEN(S_DFLT[15:0])) u_b (
    .clock(clock), .reset(reset), .bist_start(bist_start), .bist_abort(bist_abort),
    .func_req(func_req), .grant_o(grant_b), .core(if_b), .bist_busy(busy_b),
    .bist_end(end_b), .pass_fail(pass_b), .signature_out(sig_b)
  );

  bist_engine #(.N_CH(8), .MISR_W(12), .MISR_POLY(12'h021), .N_PATTERNS(1),
                .SCAN_LEN(1), .GOLDEN(S_SWEEP[11:0])) u_c (
    .clock(clock), .reset(reset), .bist_start(bist_start), .bist_abort(bist_abort),
    .func_req(func_req8), .grant_o(grant_c), .core(if_c), .bist_busy(busy_c),
    .bist_end(end_c), .pass_fail(pass_c), .signature_out(sig_c)
  );

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    num_checks++;
    if (actual !== expected) begin
      num_errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
    end
  endtask

  // Drive control inputs away from the active edge.
  task automatic applyStimulus(input logic start, input logic abort);
    @(negedge clock);
    bist_start = start;
    bist_abort = abort;
  endtask

  // Start a run and follow it edge by edge; edge 0 samples bist_start.
  // Optional abort / reset injection at a given edge; returns edges until bist_end.
  task automatic runBist(input int abort_at, input int reset_at, output int done_edge,
                         output int c_edge, output int rst_cycles);
    done_edge  = -1;
    c_edge     = -1;
    rst_cycles = 0;
    applyStimulus(1'b1, 1'b0);
    for (int cyc = 0; cyc < 200; cyc++) begin
      @(posedge clock);
      #1;
      if (if_a.dut_reset) rst_cycles++;
      if (cyc == 2) bist_start = 1'b0;
      if (c_edge < 0 && end_c) c_edge = cyc;
      if (cyc == 0) checkOutput("end_falls_on_init", 32'(end_a), 32'd0);
      if (cyc == 1 && abort_at < 0 && reset_at < 0) begin
        checkOutput("run_req_is_seed", 32'(if_a.dut_req), 32'h1);
        checkOutput("run_grant_o_zero", 32'(grant_a), 32'h0);
      end
      if (cyc == 65 && abort_at < 0 && reset_at < 0)
        checkOutput("scan_en_in_scan", 32'(if_a.dut_scan_en), 32'd1);
      if (cyc == abort_at) return;
      if (cyc == reset_at) return;
      if (end_a) begin
        done_edge = cyc;
        return;
      end
    end
    checkOutput("run_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    int done_edge, c_edge, rst_cycles;
    logic [15:0] frozen;
    reset      = 1'b0;
    bist_start = 1'b0;
    bist_abort = 1'b0;
    fault_en   = 1'b0;
    func_req   = 4'h0;
    func_req8  = 8'h00;
    #1;
    checkOutput("rst_busy", 32'(busy_a), 32'd0);
    checkOutput("rst_end", 32'(end_a), 32'd0);
    checkOutput("rst_sig", 32'(sig_a), 32'd0);
    checkOutput("rst_dut_reset", 32'(if_a.dut_reset), 32'd1);
    checkOutput("rst_scan_en", 32'(if_a.dut_scan_en), 32'd0);
    repeat (2) @(negedge clock);
    reset = 1'b1;

    // Functional passthrough.
    func_req = 4'b1010;
    #1;
    checkOutput("pt_grant_o", 32'(grant_a), 32'hA);
    checkOutput("pt_dut_req", 32'(if_a.dut_req), 32'hA);
    checkOutput("pt_busy", 32'(busy_a), 32'd0);
    checkOutput("pt_scan_en", 32'(if_a.dut_scan_en), 32'd0);
    checkOutput("pt_dut_reset", 32'(if_a.dut_reset), 32'd0);

    // Full run with start held over the first busy edges.
    runBist(-1, -1, done_edge, c_edge, rst_cycles);
    checkOutput("done_edge", 32'(done_edge), 32'd73);
    checkOutput("dut_reset_cycles", 32'(rst_cycles), 32'd1);
    checkOutput("sig_dflt", 32'(sig_a), S_DFLT);
    checkOutput("pass_dflt_golden", 32'(pass_a), 32'(S_DFLT[15:0] == 16'h6BD2));
    checkOutput("sig_b", 32'(sig_b), S_DFLT);
    checkOutput("pass_b_golden_s", 32'(pass_b), 32'd1);
    checkOutput("done_busy", 32'(busy_a), 32'd0);
    checkOutput("sweep_done_edge", 32'(c_edge), 32'd3);
    checkOutput("sweep_sig", 32'(sig_c), S_SWEEP);
    checkOutput("sweep_pass", 32'(pass_c), 32'd1);

    // Faulty core: grant bit 2 stuck at 0.
    fault_en = 1'b1;
    runBist(-1, -1, done_edge, c_edge, rst_cycles);
    checkOutput("fault_pass", 32'(pass_b), 32'd0);
    checkOutput("fault_sig_differs", 32'(sig_b != S_DFLT[15:0]), 32'd1);
    checkOutput("fault_sig_model", 32'(sig_b), S_FAULT);
    fault_en = 1'b0;

    // Abort during RUN, then restart.
    runBist(20, -1, done_edge, c_edge, rst_cycles);
    bist_abort = 1'b1;
    @(posedge clock);
    #1;
    checkOutput("abort_busy", 32'(busy_a), 32'd0);
    checkOutput("abort_end", 32'(end_a), 32'd0);
    checkOutput("abort_pass", 32'(pass_a), 32'd0);
    checkOutput("abort_grant_o", 32'(grant_a), 32'hA);
    frozen = sig_a;
    bist_abort = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    checkOutput("abort_sig_frozen", 32'(sig_a), 32'(frozen));
    runBist(-1, -1, done_edge, c_edge, rst_cycles);
    checkOutput("restart_done_edge", 32'(done_edge), 32'd73);
    checkOutput("restart_sig", 32'(sig_a), S_DFLT);

    // Reset pulled low during SCAN cycle 3.
    runBist(-1, 67, done_edge, c_edge, rst_cycles);
    checkOutput("pre_reset_scanning", 32'(if_a.dut_scan_en), 32'd1);
    reset = 1'b0;
    #1;
    checkOutput("mid_rst_busy", 32'(busy_a), 32'd0);
    checkOutput("mid_rst_end", 32'(end_a), 32'd0);
    checkOutput("mid_rst_pass", 32'(pass_a), 32'd0);
    checkOutput("mid_rst_sig", 32'(sig_a), 32'd0);
    checkOutput("mid_rst_dut_reset", 32'(if_a.dut_reset), 32'd1);
    checkOutput("mid_rst_scan_en", 32'(if_a.dut_scan_en), 32'd0);
    checkOutput("mid_rst_scan_in", 32'(if_a.dut_scan_in), 32'd0);
    @(negedge clock);
    reset = 1'b1;

    // Start and abort together in IDLE.
    applyStimulus(1'b1, 1'b1);
    repeat (3) @(posedge clock);
    #1;
    checkOutput("start_abort_busy", 32'(busy_a), 32'd0);
    checkOutput("start_abort_dut_reset", 32'(if_a.dut_reset), 32'd0);
    applyStimulus(1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", num_errors, num_checks);
    $finish;
  end

endmodule

// File: doc/bist_engine.md
# bist_engine

Parametrised built-in self-test engine for an N-channel request/grant arbiter with one internal scan chain. It sits between the chip pins and the arbiter core. In functional mode it passes requests and grants straight through. In BIST mode it:
- resets the core,
- drives LFSR patterns onto the requests,
- unloads the scan chain,
- compacts grants and scan data into a MISR,
- compares the result against a golden signature.

## Interface
- N_CH, 4: request/grant channel count (1..16)
- LFSR_W, 16: pattern generator width; must be ≥ N_CH
- LFSR_TAPS, 16'hB400: feedback tap mask
- LFSR_SEED, 16'hACE1: seed value; must be nonzero
- MISR_W, 16: signature width; must be ≥ N_CH+1
- MISR_POLY, 16'h1021: MISR feedback polynomial
- N_PATTERNS, 64: number of RUN cycles (≥1)
- SCAN_LEN, 8: number of scan-unload cycles (≥1)
- GOLDEN, 16'h6BD2: expected signature
- clock  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset of the whole engine
- bist_start  in  1  start request (level, sampled)
- bist_abort  in  1  abort request (level, sampled)
- func_req  in  N_CH  functional request inputs
- grant_o  out  N_CH  functional grant outputs
- dut_req  out  N_CH  requests to the core
- dut_grant  in  N_CH  grants from the core
- dut_reset  out  1  active-high core reset
- dut_scan_en  out  1  core scan enable
- dut_scan_in  out  1  core scan input
- dut_scan_out  in  1  core scan output
- bist_busy  out  1  high in INIT/RUN/SCAN
- bist_end  out  1  high in DONE
- pass_fail  out  1  high when the signature matches GOLDEN; valid only with bist_end
- signature_out  out  MISR_W  current MISR value

## Operation
- FSM states: IDLE, INIT, RUN, SCAN, DONE.
- Transitions:
  - IDLE/DONE → INIT when bist_start=1 and bist_abort=0.
  - INIT → RUN after 1 cycle.
  - RUN → SCAN after N_PATTERNS cycles.
  - SCAN → DONE after SCAN_LEN cycles.
  - DONE holds until the next start.
- Abort: bist_abort=1 in INIT, RUN or SCAN → IDLE at the next edge. Abort takes priority over every other transition and over a simultaneous start.
- bist_start while busy is ignored.
- INIT: lfsr←LFSR_SEED, misr←0, cycle counter←0. dut_reset=1.
- LFSR update each RUN/SCAN cycle: lfsr←{lfsr[LFSR_W-2:0], ^(lfsr & LFSR_TAPS)}. The LFSR holds in all other states.
- MISR update each RUN/SCAN cycle: misr←(misr<<1) ^ (misr[MISR_W-1] ? MISR_POLY : 0) ^ zero_ext({s, dut_grant}).
  - s=0 in RUN.
  - s=dut_scan_out in SCAN.
  - The MISR holds in all other states.
- Outputs while busy:
  - dut_req = lfsr[N_CH-1:0]
  - grant_o = 0
  - dut_scan_en = 1 only in SCAN
  - dut_scan_in = lfsr[0] in SCAN, 0 otherwise
- Outputs while not busy: dut_req = func_req, grant_o = dut_grant, dut_scan_en = 0, dut_scan_in = 0.
- dut_reset = ~reset | (state==INIT).
- pass_fail is registered on entry to DONE as (misr==GOLDEN). It is forced to 0 outside DONE.
- Cycle counter width is $clog2(N_PATTERNS+SCAN_LEN+1). The counter is cleared on entry to SCAN and DONE.

## Timing
- While reset=0: state=IDLE, lfsr=LFSR_SEED, misr=0, counter=0, bist_busy=0, bist_end=0, pass_fail=0, signature_out=0, dut_reset=1, scan outputs 0.
- Latency, with the edge that samples bist_start counted as edge 0:
  - INIT occupies the cycle after edge 0.
  - RUN occupies edges 1..N_PATTERNS.
  - SCAN occupies the next SCAN_LEN cycles.
  - bist_end and pass_fail rise after edge N_PATTERNS+SCAN_LEN+1 (edge 73 at defaults).
- The MISR samples dut_grant at the same edge the LFSR advances, so the grant compacted at a RUN edge is the core's response to the previous pattern.
- Reset asserted mid-operation returns to IDLE immediately, asynchronously. The signature is cleared.
- Abort freezes signature_out at its last value. bist_end and pass_fail remain 0.
- Restart from DONE discards the old result: bist_end falls at the edge that enters INIT.

## Test plan
- Functional passthrough: func_req=4'b1010, core loopback grant=req → grant_o=4'b1010, bist_busy=0, dut_scan_en=0.
- Full BIST at defaults with a behavioural core and reference-model signature S:
  - dut_reset is high for exactly 1 cycle.
  - bist_end rises after edge 73.
  - signature_out=S; pass_fail=(S==GOLDEN).
  - Rerun with GOLDEN overridden to S → pass_fail=1.
- Faulty core (grant bit 2 stuck at 0) with GOLDEN=S → pass_fail=0 and signature_out≠S.
- Abort asserted at RUN cycle 20 → IDLE next edge; bist_busy=0, bist_end=0; grant_o passes through again. A restart completes with the same S.
- reset pulled low during SCAN cycle 3 → all outputs at reset values immediately. bist_start held during busy has no effect. Start and abort asserted together in IDLE → remains in IDLE.
- Parameter sweep N_CH=8, MISR_W=12, N_PATTERNS=1, SCAN_LEN=1 → bist_end after edge 3, and the signature matches the reference model.
